// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory side of the pipeline. It takes one load or store per
//   req_valid/req_ready handshake and drives a word-wide synchronous SRAM that
//   has byte enables. Load data is aligned and then sign- or zero-extended.
//   An access that crosses a word boundary becomes two SRAM accesses. When
//   MISALIGNED_EN=0, such an access is rejected with rsp_err instead. The
//   response feeds writeback mux input 2'b11.
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_read/req_write    load / store select (exactly one must be set)
//   req_width             00 word, 01 half, 10 byte, 11 illegal
//   req_signed            load extension: 1 sign, 0 zero
//   req_addr, req_wdata   byte address and LSB-justified store data
//   rsp_valid/err/rdata   one-cycle completion pulse, error flag, load result
//   mem_en/we/be/addr/wdata, mem_rdata   synchronous SRAM port (read data one cycle later)
module load_store_unit #(
  parameter int ADDR_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WW = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_ACC1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic              read_q, read_d;
  logic [1:0]        width_q, width_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       part0_q, part0_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [WW-1:0]     mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              handshake;
  logic              cur_read;
  logic [1:0]        cur_width;
  logic              cur_signed;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic              split;
  logic              illegal;
  logic [31:0]       wdata_masked;
  logic [63:0]       wdata_lanes;
  logic [31:0]       ld_p0, ld_p1, ld_win, ld_res;

  assign handshake = req_valid & req_ready_q;

  // Request view: the live inputs in the handshake cycle, the latched copy afterwards.
  // This lets the first SRAM access go out on the cycle right after the handshake.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_read   = req_read;
      cur_width  = req_width;
      cur_signed = req_signed;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end else begin
      cur_read   = read_q;
      cur_width  = width_q;
      cur_signed = signed_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
  end

  // Access geometry: lanes across two adjacent words, split detection and lane-aligned store data.
  always_comb begin
    off = cur_addr[1:0];
    case (cur_width)
      2'b00:   size_mask = 4'hF;
      2'b01:   size_mask = 4'h3;
      2'b10:   size_mask = 4'h1;
      default: size_mask = 4'h0;
    endcase
    case (cur_width)
      2'b00:   wdata_masked = cur_wdata;
      2'b01:   wdata_masked = {16'h0000, cur_wdata[15:0]};
      2'b10:   wdata_masked = {24'h000000, cur_wdata[7:0]};
      default: wdata_masked = 32'h0000_0000;
    endcase
    // The upper nibble of lane_mask holds the lanes that spill into the next word.
    lane_mask   = {4'b0000, size_mask} << off;
    split       = |lane_mask[7:4];
    wdata_lanes = {32'h0000_0000, wdata_masked} << {off, 3'b000};
    illegal     = (cur_width == 2'b11) || (cur_read == req_write && state_q == S_IDLE)
                  || (cur_read == 1'b0 && req_write == 1'b0 && state_q == S_IDLE)
                  || (!MISALIGNED_EN && split);
  end

  // Load assembly: the second word supplies the high part, then shift down by offset and extend.
  always_comb begin
    if (state_q == S_WAIT0) begin
      ld_p0 = mem_rdata;
    end else begin
      ld_p0 = part0_q;
    end
    if (state_q == S_WAIT1) begin
      ld_p1 = mem_rdata;
    end else begin
      ld_p1 = 32'h0000_0000;
    end
    ld_win = 32'({ld_p1, ld_p0} >> {off, 3'b000});
    case (cur_width)
      2'b00:   ld_res = ld_win;
      2'b01:   ld_res = cur_signed ? {{16{ld_win[15]}}, ld_win[15:0]} : {16'h0000, ld_win[15:0]};
      2'b10:   ld_res = cur_signed ? {{24{ld_win[7]}}, ld_win[7:0]} : {24'h000000, ld_win[7:0]};
      default: ld_res = 32'h0000_0000;
    endcase
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d = illegal ? S_DONE : S_ACC0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC0: begin
        if (cur_read) begin
          state_d = S_WAIT0;
        end else begin
          state_d = split ? S_ACC1 : S_DONE;
        end
      end
      S_WAIT0: state_d = split ? S_ACC1 : S_DONE;
      S_ACC1:  state_d = cur_read ? S_WAIT1 : S_DONE;
      S_WAIT1: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, all decoded from the upcoming state so every output is a flop.
  always_comb begin
    read_d      = read_q;
    width_d     = width_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    part0_d     = part0_q;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'h0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (state_q == S_IDLE && handshake) begin
      read_d   = req_read;
      width_d  = req_width;
      signed_d = req_signed;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end else begin
      read_d   = read_q;
    end

    if (state_q == S_WAIT0) begin
      part0_d = mem_rdata;
    end else begin
      part0_d = part0_q;
    end

    case (state_d)
      S_ACC0: begin
        mem_en_d    = 1'b1;
        mem_we_d    = ~cur_read;
        mem_be_d    = lane_mask[3:0];
        mem_addr_d  = cur_addr[ADDR_W-1:2];
        mem_wdata_d = wdata_lanes[31:0];
      end
      S_ACC1: begin
        mem_en_d    = 1'b1;
        mem_we_d    = ~cur_read;
        mem_be_d    = lane_mask[7:4];
        // The word index wraps naturally at the top of the address space.
        mem_addr_d  = cur_addr[ADDR_W-1:2] + {{(WW-1){1'b0}}, 1'b1};
        mem_wdata_d = wdata_lanes[63:32];
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        // DONE straight from IDLE only happens for a rejected request.
        if (state_q == S_IDLE) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = cur_read ? ld_res : 32'h0000_0000;
        end
      end
      default: begin
        mem_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      width_q     <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= 32'h0000_0000;
      part0_q     <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= {WW{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      width_q     <= width_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      part0_q     <= part0_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. A scoreboard queue receives the expected
// response at every handshake. A forked monitor pops and compares at each
// rsp_valid. A byte-addressed reference memory supplies the expected load data.
// A second instance with MISALIGNED_EN=0 shares the request inputs.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  logic        req_ready2, rsp_valid2, rsp_err2, mem_en2, mem_we2;
  logic [31:0] rsp_rdata2, mem_wdata2;
  logic [3:0]  mem_be2;
  logic [29:0] mem_addr2;
  logic [31:0] mem_rdata2 = 32'h0;

  load_store_unit #(.ADDR_W(32), .MISALIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_width(req_width),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  load_store_unit #(.ADDR_W(32), .MISALIGNED_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_read(req_read), .req_write(req_write), .req_width(req_width),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_be(mem_be2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  exp_t exp_q[$];
  acc_t log_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   en2_cnt = 0;
  int   rsp2_cnt = 0;
  logic err2_last = 1'b0;
  int   lat2_last = 0;

  logic [31:0] sram [logic [29:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [29:0] w);
    if (sram.exists(w)) return sram[w];
    return init_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  // Synchronous SRAM with byte enables; it also keeps a log of every access.
  always @(posedge clk) begin
    if (mem_en) begin
      acc_t e;
      logic [31:0] w;
      e.we = mem_we; e.addr = mem_addr; e.be = mem_be; e.wdata = mem_wdata;
      log_q.push_back(e);
      if (mem_we) begin
        w = sram_rd(mem_addr);
        for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        sram[mem_addr] = w;
      end else begin
        mem_rdata <= sram_rd(mem_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] wd, input logic sg,
                       input logic [31:0] a, input logic [31:0] wdat, output int base);
    int size, nacc, lat, bound;
    logic illegal, split;
    logic [31:0] val;
    exp_t e;
    size    = (wd == 2'b00) ? 4 : (wd == 2'b01) ? 2 : (wd == 2'b10) ? 1 : 0;
    illegal = (wd == 2'b11) || (rd == wr);
    split   = !illegal && ((int'(a[1:0]) + size) > 4);
    val = 32'h0;
    if (!illegal && rd) begin
      for (int i = 0; i < size; i++) val[8*i +: 8] = ref_byte(a + 32'(i));
      if (sg && val[8*size-1]) for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
    end
    if (!illegal && wr) for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = wdat[8*i +: 8];
    nacc = illegal ? 0 : (split ? 2 : 1);
    lat  = illegal ? 1 : (wr ? (split ? 3 : 2) : (split ? 5 : 3));
    base = log_q.size();
    @(negedge clk);
    req_read = rd; req_write = wr; req_width = wd; req_signed = sg;
    req_addr = a; req_wdata = wdat; req_valid = 1'b1;
    bound = 0;
    while (!req_ready && bound < 20) begin @(negedge clk); bound++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    last_hs = cyc;
    e.rdata = val; e.err = illegal; e.hs = cyc; e.lat = lat;
    exp_q.push_back(e);
    req_valid = 1'b0;
    req_read = 1'($urandom); req_write = 1'($urandom); req_width = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    bound = 0;
    while (exp_q.size() != 0 && bound < 20) begin @(negedge clk); bound++; end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("sram_access_count", 32'(log_q.size() - base), 32'(nacc));
  endtask

  initial begin
    int b, e2, r2, sel;
    logic rd, wr;
    logic [1:0] wd;
    logic [31:0] a;

    // Scoreboard monitor, plus an observer of the MISALIGNED_EN=0 instance.
    fork
      forever begin
        @(negedge clk);
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, x.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(x.err));
            chk("rsp_latency", 32'(cyc - x.hs + 1), 32'(x.lat));
          end
        end
        if (mem_en2) en2_cnt++;
        if (rsp_valid2) begin
          rsp2_cnt++;
          err2_last = rsp_err2;
          lat2_last = cyc - last_hs + 1;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_be", 32'(mem_be), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    // Aligned store word
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, b);
    chk("sw_acc0_addr", 32'(log_q[b].addr), 32'h40);
    chk("sw_acc0_be", 32'(log_q[b].be), 32'hF);
    chk("sw_acc0_wdata", log_q[b].wdata, 32'hDEAD_BEEF);
    chk("sw_acc0_we", 32'(log_q[b].we), 32'd1);

    // Byte and half loads from word 0x40 = 0x80FF7F01
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h80FF_7F01, b);
    do_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0, b);
    do_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, b);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, b);
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, b);
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, b);

    // Split half store
    do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h1234_ABCD, b);
    chk("sh_acc0_addr", 32'(log_q[b].addr), 32'h40);
    chk("sh_acc0_be", 32'(log_q[b].be), 32'h8);
    chk("sh_acc0_byte", 32'(log_q[b].wdata[31:24]), 32'hCD);
    chk("sh_acc1_addr", 32'(log_q[b+1].addr), 32'h41);
    chk("sh_acc1_be", 32'(log_q[b+1].be), 32'h1);
    chk("sh_acc1_byte", 32'(log_q[b+1].wdata[7:0]), 32'hAB);

    // Split word load that wraps to word 0
    do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0, b);
    chk("lw_wrap_acc0_addr", 32'(log_q[b].addr), 32'h3FFF_FFFF);
    chk("lw_wrap_acc1_addr", 32'(log_q[b+1].addr), 32'h0);

    // Illegal requests
    do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, b);
    do_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h5555_5555, b);
    do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, b);

    // Misaligned word load as seen by the MISALIGNED_EN=0 instance
    e2 = en2_cnt; r2 = rsp2_cnt;
    do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0, b);
    chk("mis0_rsp_count", 32'(rsp2_cnt - r2), 32'd1);
    chk("mis0_err", 32'(err2_last), 32'd1);
    chk("mis0_latency", 32'(lat2_last), 32'd1);
    chk("mis0_no_mem", 32'(en2_cnt - e2), 32'd0);

    // Reset asserted while in WAIT0
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b0; req_width = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0000_0104; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized traffic around the 0x100 window and the top of memory
    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin rd = 1'b1; wr = 1'b1; end
      else if (sel == 1) begin rd = 1'b0; wr = 1'b0; end
      else if (sel < 11) begin rd = 1'b1; wr = 1'b0; end
      else begin rd = 1'b0; wr = 1'b1; end
      sel = int'($urandom_range(0, 9));
      wd = (sel == 9) ? 2'b11 : 2'(sel % 3);
      a = ($urandom_range(0, 1) == 1) ? 32'h0000_0100 : 32'hFFFF_FFF0;
      a = a + $urandom_range(0, 15);
      do_op(rd, wr, wd, 1'($urandom), a, $urandom, b);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
